// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the clock-enable pipeline controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Occupancy must be able to represent 0..latency inclusive.
  function automatic int occ_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/pipe_occ_counter.sv
// Up/down counter of tokens in flight, with synchronous clear.
// Latency: count reflects inc/dec/clr one cycle after they are sampled.
// Backpressure: none; inc and dec in the same cycle cancel.
//
// Ports: clk, rst (async active-high), clr (sync, wins over inc/dec),
//        inc, dec, count[W-1:0].
module pipe_occ_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + W'(1);
    end else if (dec && !inc) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pipe_ce_ctrl.sv
// Valid/ready wrapper that owns the shared ce of a fixed-latency delay-line pipeline.
// Latency: C_LATENCY ce-qualified cycles from accept to m_valid; each stall adds one.
// Backpressure: m_valid & !m_ready drops pipe_ce (combinationally) and s_ready.
//
// Ports: clk, rst (async active-high); enable, flush_req; s_valid/s_ready upstream;
//        m_valid/m_ready downstream; pipe_ce, pipe_clr to the datapath;
//        occupancy, busy, done status; stall_cycles, accept_count statistics.
// Optional: define PIPE_CE_CTRL_STATS_EN to build the saturating statistics
//           counters; otherwise both counter ports are tied to 0.
module pipe_ce_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int C_LATENCY   = 4,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               flush_req,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               pipe_ce,
  output logic                               pipe_clr,
  output logic [occ_width(C_LATENCY)-1:0]    occupancy,
  output logic                               busy,
  output logic                               done,
  output logic [C_CNT_WIDTH-1:0]             stall_cycles,
  output logic [C_CNT_WIDTH-1:0]             accept_count
);

  state_t               state;
  state_t               state_nxt;
  logic [C_LATENCY-1:0] vld;
  logic                 accept;
  logic                 emit;
  logic                 drain_done;

  assign m_valid = vld[C_LATENCY-1];
  assign emit    = m_valid & m_ready;
  assign accept  = s_valid & s_ready;
  assign busy    = (state != ST_IDLE) || (occupancy != '0);

  // Next state and the combinational handshake. pipe_ce only freezes when the
  // output token is actually blocked, so a stall releases with no bubble.
  always_comb begin
    state_nxt  = state;
    pipe_ce    = 1'b0;
    s_ready    = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pipe_ce = !(m_valid && !m_ready);
        // A beat offered alongside a flush would be cleared anyway; refuse it.
        s_ready = pipe_ce && !flush_req;
        if (!enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        pipe_ce = !(m_valid && !m_ready);
        if (occupancy == '0) begin
          drain_done = 1'b1;
          state_nxt  = enable ? ST_RUN : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (flush_req) begin
      state_nxt  = ST_FLUSH;
      drain_done = 1'b0;
    end
  end

  // pipe_clr and done are high during the FLUSH cycle itself; a drain's done
  // appears in the first cycle after DRAIN is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pipe_clr <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pipe_clr <= flush_req;
      done     <= flush_req | drain_done;
    end
  end

  // Token line mirrors the datapath: one bit per stage, shifted only on ce.
  // Tokens are dropped on the flush request edge so m_valid is already low
  // during the FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (flush_req) begin
      vld <= '0;
    end else if (pipe_ce) begin
      vld <= {vld[C_LATENCY-2:0], accept};
    end
  end

  pipe_occ_counter #(
    .W(occ_width(C_LATENCY))
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_req),
    .inc   (accept),
    .dec   (emit),
    .count (occupancy)
  );

`ifdef PIPE_CE_CTRL_STATS_EN
  logic [C_CNT_WIDTH-1:0] stall_q;
  logic [C_CNT_WIDTH-1:0] accept_q;

  // Saturating; deliberately untouched by flush so they span flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      accept_q <= '0;
    end else begin
      if (m_valid && !m_ready && (stall_q != '1)) stall_q <= stall_q + C_CNT_WIDTH'(1);
      if (accept && (accept_q != '1)) accept_q <= accept_q + C_CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign accept_count = accept_q;
`else
  assign stall_cycles = '0;
  assign accept_count = '0;
`endif

endmodule
